// File: rtl/beat_split_pkg.sv
// Shared defaults and state encoding for the beat_split serializer and the
// accumulator path it feeds.
package beat_split_pkg;

    localparam int BEATS_DEF  = 4;
    localparam int BEAT_W_DEF = 8;
    localparam int SUM_W_DEF  = BEAT_W_DEF + $clog2(BEATS_DEF);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/beat_split.sv
// Width-down serializer: takes one BEATS*BEAT_W word and emits it LSB beat first,
// tagging the last beat with the reference sum of the whole word.
module beat_split
    import beat_split_pkg::*;
#(
    parameter int BEATS  = BEATS_DEF,
    parameter int BEAT_W = BEAT_W_DEF,
    parameter int SUM_W  = BEAT_W + $clog2(BEATS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    output logic                    ready_in,
    input  logic [BEATS*BEAT_W-1:0] data_in,
    output logic                    valid_out,
    input  logic                    ready_out,
    output logic [BEAT_W-1:0]       data_out,
    output logic                    last_out,
    output logic [SUM_W-1:0]        sum_out
);

    localparam int CNT_W = $clog2(BEATS);

    state_t                  state;
    logic [BEATS*BEAT_W-1:0] word;
    logic [CNT_W-1:0]        cnt;
    logic [SUM_W-1:0]        sum_q;
    logic [SUM_W-1:0]        sum_in;
    logic                    is_last;
    logic                    in_xfer;
    logic                    out_xfer;

    // SUM_W is wide enough that the sum of BEATS full-scale beats cannot overflow.
    always_comb begin
        sum_in = '0;
        for (int k = 0; k < BEATS; k++)
            sum_in = sum_in + SUM_W'(data_in[k*BEAT_W +: BEAT_W]);
    end

    assign is_last   = (state == SEND) && (cnt == CNT_W'(BEATS - 1));
    assign valid_out = (state == SEND);
    assign data_out  = valid_out ? word[cnt*BEAT_W +: BEAT_W] : '0;
    assign last_out  = is_last;
    assign sum_out   = is_last ? sum_q : '0;

    assign out_xfer  = valid_out & ready_out;
    // Accepting on the last-beat transfer is what makes back-to-back words gapless.
    assign ready_in  = !rst && ((state == IDLE) || (out_xfer && is_last));
    assign in_xfer   = valid_in & ready_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            word  <= '0;
            sum_q <= '0;
        end else if (in_xfer) begin
            word  <= data_in;
            sum_q <= sum_in;
            cnt   <= '0;
            state <= SEND;
        end else if (out_xfer) begin
            if (is_last) begin
                cnt   <= '0;
                state <= IDLE;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_beat_split.sv
// Randomized and directed bench for beat_split; accepted words are expanded into
// expected beats in a queue and a separate monitor checks every output cycle.
module tb_beat_split;
    import beat_split_pkg::*;

    localparam int BEATS  = BEATS_DEF;
    localparam int BEAT_W = BEAT_W_DEF;
    localparam int SUM_W  = SUM_W_DEF;
    localparam int WORD_W = BEATS * BEAT_W;

    typedef struct {
        logic [BEAT_W-1:0] d;
        logic              last;
        logic [SUM_W-1:0]  s;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              valid_in;
    logic              ready_in;
    logic [WORD_W-1:0] data_in;
    logic              valid_out;
    logic              ready_out;
    logic [BEAT_W-1:0] data_out;
    logic              last_out;
    logic [SUM_W-1:0]  sum_out;

    exp_t             q[$];
    logic [SUM_W-1:0] sums[$];
    int               checks   = 0;
    int               failures = 0;
    bit               acc;
    bit               prev_rst = 1'b0;

    beat_split dut (
        .clk      (clk),
        .rst      (rst),
        .valid_in (valid_in),
        .ready_in (ready_in),
        .data_in  (data_in),
        .valid_out(valid_out),
        .ready_out(ready_out),
        .data_out (data_out),
        .last_out (last_out),
        .sum_out  (sum_out)
    );

    always #5 clk = ~clk;

    function automatic void chk(bit ok, string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Expected beats of a word: LSB beat first, sum of all beats on the last one.
    function automatic void push_word(logic [WORD_W-1:0] w);
        int   total = 0;
        exp_t e;
        for (int k = 0; k < BEATS; k++) total += int'(w[k*BEAT_W +: BEAT_W]);
        for (int k = 0; k < BEATS; k++) begin
            e.d    = w[k*BEAT_W +: BEAT_W];
            e.last = (k == BEATS - 1);
            e.s    = e.last ? SUM_W'(total) : '0;
            q.push_back(e);
        end
    endfunction

    // One cycle: inputs were set right after a negedge; record acceptance, move on.
    task automatic step();
        #3;
        acc = !rst && valid_in && ready_in;
        if (acc) push_word(data_in);
        @(negedge clk);
    endtask

    task automatic send_word(logic [WORD_W-1:0] w);
        int n = 0;
        valid_in = 1'b1;
        data_in  = w;
        do begin
            step();
            n++;
        end while (!acc && n < 50);
        if (!acc) chk(1'b0, "accept_timeout", 32'(n), 32'd50);
        valid_in = 1'b0;
    endtask

    // Monitor: compares outputs against the expected-beat queue every cycle.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (prev_rst) begin
                chk(!valid_out, "rst_valid", 32'(valid_out), 0);
                chk(data_out == '0, "rst_data", 32'(data_out), 0);
                chk(!last_out, "rst_last", 32'(last_out), 0);
                chk(sum_out == '0, "rst_sum", 32'(sum_out), 0);
            end
            if (rst) begin
                chk(!ready_in, "rst_ready_in", 32'(ready_in), 0);
                q.delete();
            end else begin
                chk(valid_out == (q.size() != 0), "valid_out", 32'(valid_out), 32'(q.size() != 0));
                if (q.size() == 0)
                    chk(ready_in, "ready_in_idle", 32'(ready_in), 1);
                else
                    chk(ready_in == (ready_out && q[0].last), "ready_in_busy",
                        32'(ready_in), 32'(ready_out && q[0].last));
                if (valid_out && q.size() != 0) begin
                    chk(data_out == q[0].d, "data_out", 32'(data_out), 32'(q[0].d));
                    chk(last_out == q[0].last, "last_out", 32'(last_out), 32'(q[0].last));
                    chk(sum_out == q[0].s, "sum_out", 32'(sum_out), 32'(q[0].s));
                    if (ready_out) begin
                        if (q[0].last) sums.push_back(sum_out);
                        void'(q.pop_front());
                    end
                end
            end
            prev_rst = rst;
        end
    end

    initial begin
        int  n;
        bit  pending;
        rst       = 1'b1;
        valid_in  = 1'b0;
        ready_out = 1'b0;
        data_in   = '0;
        @(negedge clk);
        repeat (3) step();
        rst = 1'b0;

        // Single word
        ready_out = 1'b1;
        sums.delete();
        send_word(32'h04030201);
        repeat (5) step();
        chk(sums.size() == 1 && sums[0] == 10'h00A, "single_sum", 32'(sums.size() ? sums[0] : 0), 32'h00A);

        // Max values
        sums.delete();
        send_word(32'hFFFFFFFF);
        repeat (5) step();
        chk(sums.size() == 1 && sums[0] == 10'h3FC, "max_sum", 32'(sums.size() ? sums[0] : 0), 32'h3FC);

        // Backpressure on beat 1
        send_word(32'h44332211);
        step();
        ready_out = 1'b0;
        repeat (3) begin
            #3;
            chk(valid_out && data_out == 8'h22, "stall_data", 32'(data_out), 32'h22);
            chk(!ready_in, "stall_ready_in", 32'(ready_in), 0);
            @(negedge clk);
        end
        ready_out = 1'b1;
        #3;
        chk(data_out == 8'h22, "stall_release", 32'(data_out), 32'h22);
        @(negedge clk);
        #3;
        chk(data_out == 8'h33, "resume_data", 32'(data_out), 32'h33);
        @(negedge clk);
        repeat (4) step();

        // Back-to-back: second word accepted exactly on word 1's last-beat cycle
        sums.delete();
        send_word(32'h04030201);
        valid_in = 1'b1;
        data_in  = 32'h08070605;
        n = 0;
        do begin
            step();
            n++;
        end while (!acc && n < 50);
        valid_in = 1'b0;
        chk(n == BEATS, "b2b_accept_cycle", 32'(n), 32'(BEATS));
        repeat (6) step();
        chk(sums.size() == 2 && sums[0] == 10'h00A && sums[1] == 10'h01A, "b2b_sums",
            32'(sums.size() == 2 ? {sums[0], sums[1]} : 0), {10'h00A, 10'h01A});

        // Reset mid-word
        send_word(32'hDDCCBBAA);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #3;
        chk(!valid_out && data_out == '0 && ready_in, "post_rst_state",
            {valid_out, data_out, ready_in}, {1'b0, 8'h00, 1'b1});
        @(negedge clk);
        sums.delete();
        send_word(32'h04030201);
        #3;
        chk(data_out == 8'h01, "post_rst_first_beat", 32'(data_out), 32'h01);
        @(negedge clk);
        repeat (5) step();
        chk(sums.size() == 1 && sums[0] == 10'h00A, "post_rst_sum", 32'(sums.size() ? sums[0] : 0), 32'h00A);

        // Ignored input while mid-word
        send_word(32'h5A6B7C8D);
        valid_in = 1'b1;
        data_in  = 32'hDEADBEEF;
        n = 0;
        repeat (2) begin
            step();
            if (acc) n++;
        end
        valid_in = 1'b0;
        chk(n == 0, "ignored_accept", 32'(n), 0);
        repeat (5) step();

        // Randomized traffic with random backpressure and occasional full-scale words
        pending = 1'b0;
        repeat (600) begin
            if (!pending && ($urandom % 3) != 0) begin
                pending = 1'b1;
                data_in = (($urandom % 8) == 0) ? '1 : WORD_W'($urandom);
            end
            valid_in  = pending;
            ready_out = ($urandom % 4) != 0;
            if (($urandom % 200) == 0) rst = 1'b1;
            step();
            if (acc || rst) pending = 1'b0;
            rst = 1'b0;
        end
        valid_in  = 1'b0;
        ready_out = 1'b1;
        repeat (10) step();
        chk(q.size() == 0, "drain", 32'(q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/beat_split.md
# beat_split

Width-down serializer feeding the four-beat accumulator path. Accepts one packed word of BEATS×BEAT_W bits through a valid/ready handshake and emits it as BEATS consecutive BEAT_W-bit beats, least-significant beat first, with valid/ready on the output side. The last beat carries a flag and the reference sum of all beats in the word, so the downstream accumulator's result can be checked in-line. It sits between the word-wide producer and the byte-stream accumulator.

## Interface
- BEATS, default 4: beats per word; power of two, ≥2
- BEAT_W, default 8: beat width in bits
- SUM_W, default BEAT_W+$clog2(BEATS) (10): width of the reference sum
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- valid_in  input  1  upstream word valid
- ready_in  output  1  block can accept a word this cycle
- data_in  input  BEATS*BEAT_W  packed word; beat k = data_in[k*BEAT_W +: BEAT_W]
- valid_out  output  1  beat valid
- ready_out  input  1  downstream accepts the beat this cycle
- data_out  output  BEAT_W  current beat
- last_out  output  1  current beat is beat BEATS-1 of its word
- sum_out  output  SUM_W  zero-extended sum of all BEATS beats of the word; meaningful only when last_out=1, otherwise 0

## Operation
- Two states: IDLE (no word held) and SEND (word held, beats pending).
- Registers: word holding register, beat index cnt (log2 BEATS bits), sum register.
- ready_in = (state==IDLE) | (valid_out & ready_out & last_out). It is 0 while rst=1.
- Input transfer: valid_in & ready_in. On transfer, the word is latched, cnt←0, sum_out target computed from data_in (full SUM_W width, no overflow possible), state←SEND.
- In SEND, valid_out=1 and data_out = beat cnt of the held word. last_out = (cnt==BEATS-1).
- Output transfer: valid_out & ready_out. On transfer, cnt←cnt+1. On the last beat: if an input transfer occurs in the same cycle, the new word is loaded and SEND continues (zero bubble). Otherwise state←IDLE.
- Stall: while valid_out=1 and ready_out=0, data_out, last_out, sum_out and cnt stay stable. valid_out never drops before the beat transfers.
- valid_in is ignored when ready_in=0. Upstream must hold the word.
- Reset (any time, including mid-word): state←IDLE, cnt←0, the held word is discarded, and all outputs go to 0 the next cycle. No partial beats are emitted after reset.

## Timing
- Reset values: valid_out=0, data_out=0, last_out=0, sum_out=0. ready_in=1 from the first cycle after rst deasserts.
- Latency: word accepted at edge N gives beat 0 valid in cycle N+1. Outputs are registered or decoded from registered state only. ready_in is the only combinational output path (depends on ready_out).
- Throughput: one word per BEATS cycles with ready_out held at 1. There are no idle cycles between words when valid_in is continuous.
- cnt wraps from BEATS-1 to 0 only through a reload. The beat index never exceeds BEATS-1.

## Structure
- Shared package: BEATS, BEAT_W and SUM_W defaults, and the state enum (IDLE, SEND). This package is also used by the accumulator and by the bench scoreboard.
- Single module. The sum is a combinational adder tree over the input word, registered at load. No sub-module.

## Test plan
- Single word: data_in=0x04030201, ready_out=1. Expect beats 0x01,0x02,0x03,0x04 in four consecutive cycles from N+1. last_out=1 only on 0x04, with sum_out=0x00A.
- Max values: data_in=0xFFFFFFFF. Expect four beats of 0xFF and sum_out=0x3FC on the last beat (no truncation).
- Backpressure: ready_out=0 for 3 cycles during beat 1 of 0x44332211. Expect data_out to hold 0x22 with valid_out=1 and ready_in=0; the sequence resumes at 0x33 afterwards.
- Back-to-back: valid_in held high with words 0x04030201 then 0x08070605. Expect 8 consecutive beats 01..08 with no gap. ready_in=1 exactly on the last-beat cycle of word 1. The two last_out pulses carry sum_out 0x00A and 0x01A.
- Reset mid-word: assert rst after beat 1 of 0xDDCCBBAA. Next cycle expect valid_out=0 and all outputs 0. After release, word 0x04030201 streams cleanly from beat 0x01.
- Ignored input: valid_in=1 with a new word while in SEND and not on the last beat. The word is not captured and the output stream is unchanged.
